// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types and constants for the N-slot SDRAM ROM arbiter.
package jtframe_rom_arb_pkg;
  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 16;
  localparam int MAX_SLOT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/jtframe_rom_arb_cache.sv
// One client slot: single-word cache (tag/data/valid), hit compare, byte select
// and the registered ok/dout pair seen by the client.
module jtframe_rom_arb_cache
  import jtframe_rom_arb_pkg::*;
#(
  parameter int AW        = 22,
  parameter bit BYTE_SLOT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  input  logic                fill,
  input  logic [AW-1:0]       fill_tag,
  input  logic [SDRAM_DW-1:0] fill_data,
  output logic [AW-1:0]       word_addr,
  output logic                miss,
  output logic                ok,
  output logic [SDRAM_DW-1:0] dout
);
  logic                valid;
  logic [AW-1:0]       tag;
  logic [SDRAM_DW-1:0] data;
  logic                tag_hit;
  logic                fill_hit;
  logic                hit;
  logic [SDRAM_DW-1:0] word;
  logic [SDRAM_DW-1:0] sel;

  // The fill bypass lets ok rise on the cycle right after data_rdy.
  always_comb begin
    word_addr = BYTE_SLOT ? (addr >> 1) : addr;
    tag_hit   = valid && (tag == word_addr);
    fill_hit  = fill && (fill_tag == word_addr);
    miss      = cs && !tag_hit;
    hit       = cs && (tag_hit || fill_hit);
    word      = fill_hit ? fill_data : data;
    if (BYTE_SLOT) sel = {8'h00, addr[0] ? word[15:8] : word[7:0]};
    else           sel = word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
      ok    <= 1'b0;
      dout  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ok    <= 1'b0;
      dout  <= '0;
    end else begin
      if (fill) begin
        valid <= 1'b1;
        tag   <= fill_tag;
        data  <= fill_data;
      end
      ok   <= hit;
      dout <= hit ? sel : '0;
    end
  end
endmodule

// File: rtl/jtframe_rom_arb.sv
// N-slot SDRAM ROM request arbiter with per-slot single-word caches.
// Optional per-slot miss counters are built when JTFRAME_ROMARB_STATS_EN is defined.
module jtframe_rom_arb
  import jtframe_rom_arb_pkg::*;
#(
  parameter int                         NSLOT      = 4,
  parameter int                         AW         = 22,
  parameter logic [NSLOT*SDRAM_AW-1:0]  OFFSETS    = '0,
  parameter logic [NSLOT-1:0]           BYTE_SLOTS = '0,
  parameter bit                         RR_MODE    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NSLOT-1:0]          slot_cs,
  input  logic [NSLOT*AW-1:0]       slot_addr,
  output logic [NSLOT-1:0]          slot_ok,
  output logic [NSLOT*SDRAM_DW-1:0] slot_dout,
  input  logic                      downloading,
  output logic                      sdram_req,
  input  logic                      sdram_ack,
  output logic [SDRAM_AW-1:0]       sdram_addr,
  input  logic                      data_dst,
  input  logic                      data_rdy,
  input  logic [SDRAM_DW-1:0]       data_read
`ifdef JTFRAME_ROMARB_STATS_EN
  ,
  input  logic [3:0]                stats_sel,
  output logic [15:0]               stats_cnt
`endif
);
  localparam int XW = (AW > SDRAM_AW) ? AW : SDRAM_AW;

  state_t              state, state_nxt;
  logic [NSLOT-1:0]    miss;
  logic [AW-1:0]       wa [NSLOT];
  logic [3:0]          gnt, gnt_nxt, rr_ptr, rr_nxt;
  logic                found, any_miss, grant, fill_en;
  logic [AW-1:0]       gnt_tag, sel_wa;
  logic [SDRAM_AW-1:0] sel_off;
  logic [XW-1:0]       addr_sum;
  int                  idx;
  logic                unused_dst;

  assign unused_dst = data_dst;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    jtframe_rom_arb_cache #(
      .AW        (AW),
      .BYTE_SLOT (BYTE_SLOTS[i])
    ) u_cache (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (downloading),
      .cs        (slot_cs[i]),
      .addr      (slot_addr[AW*i +: AW]),
      .fill      (fill_en && (gnt == 4'(i))),
      .fill_tag  (gnt_tag),
      .fill_data (data_read),
      .word_addr (wa[i]),
      .miss      (miss[i]),
      .ok        (slot_ok[i]),
      .dout      (slot_dout[SDRAM_DW*i +: SDRAM_DW])
    );
  end

  // Search starts at rr_ptr (slot after the last grant) in RR mode, slot 0 otherwise.
  always_comb begin
    gnt_nxt = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NSLOT; k++) begin
      idx = RR_MODE ? int'(rr_ptr) + k : k;
      if (idx >= NSLOT) idx = idx - NSLOT;
      for (int i = 0; i < NSLOT; i++) begin
        if (!found && (i == idx) && miss[i]) begin
          found   = 1'b1;
          gnt_nxt = 4'(i);
        end
      end
    end
    any_miss = found;
    rr_nxt   = (int'(gnt_nxt) == NSLOT - 1) ? 4'd0 : gnt_nxt + 4'd1;
  end

  always_comb begin
    sel_wa  = '0;
    sel_off = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (int'(gnt_nxt) == i) begin
        sel_wa  = wa[i];
        sel_off = OFFSETS[SDRAM_AW*i +: SDRAM_AW];
      end
    end
    addr_sum = XW'(sel_off) + XW'(sel_wa);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           state <= IDLE;
    else if (downloading) state <= IDLE;
    else                  state <= state_nxt;
  end

  // sdram_req is a request/accept handshake: once raised it stays high with a
  // stable sdram_addr until the cycle sdram_ack is seen; data follows on data_rdy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_miss)  state_nxt = REQ;
      REQ:     if (sdram_ack) state_nxt = WAIT;
      WAIT:    if (data_rdy)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (state == REQ) && !downloading;
    grant     = (state == IDLE) && any_miss && !downloading;
    fill_en   = (state == WAIT) && data_rdy && !downloading;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      gnt_tag    <= '0;
      sdram_addr <= '0;
      rr_ptr     <= '0;
    end else if (downloading) begin
      sdram_addr <= '0;
      rr_ptr     <= '0;
    end else if (grant) begin
      gnt        <= gnt_nxt;
      gnt_tag    <= sel_wa;
      sdram_addr <= addr_sum[SDRAM_AW-1:0];
      rr_ptr     <= rr_nxt;
    end
  end

`ifdef JTFRAME_ROMARB_STATS_EN
  logic [15:0] cnt [NSLOT];
  logic [15:0] cnt_sel;
  logic        dl_q;

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (int'(stats_sel) == i) cnt_sel = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q      <= 1'b0;
      stats_cnt <= '0;
      for (int i = 0; i < NSLOT; i++) cnt[i] <= '0;
    end else begin
      dl_q      <= downloading;
      stats_cnt <= cnt_sel;
      for (int i = 0; i < NSLOT; i++) begin
        if (downloading && !dl_q)
          cnt[i] <= '0;
        else if (grant && (int'(gnt_nxt) == i) && (cnt[i] != 16'hFFFF))
          cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench: a fixed-priority and a round-robin arbiter share the same
// stimulus so grant order can be compared side by side.
module tb_jtframe_rom_arb;
  localparam int NSLOT = 4;
  localparam int AW    = 22;
  localparam logic [NSLOT*22-1:0] OFFS  = {22'h0, 22'h0, 22'h0, 22'h8000};
  localparam logic [NSLOT-1:0]    BYTES = 4'b0010;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NSLOT-1:0]    slot_cs;
  logic [NSLOT*AW-1:0] slot_addr;
  logic                downloading, sdram_ack, data_dst, data_rdy;
  logic [15:0]         data_read;
  logic [NSLOT-1:0]    ok_f, ok_r;
  logic [NSLOT*16-1:0] dout_f, dout_r;
  logic                req_f, req_r;
  logic [21:0]         addr_f, addr_r;
  int                  pass_cnt = 0;
  int                  total_cnt = 0;
`ifdef JTFRAME_ROMARB_STATS_EN
  logic [3:0]          stats_sel = 4'd0;
  logic [15:0]         stats_cnt_f, stats_cnt_r;
`endif

  always #5 clk = ~clk;

  jtframe_rom_arb #(.NSLOT(NSLOT), .AW(AW), .OFFSETS(OFFS), .BYTE_SLOTS(BYTES), .RR_MODE(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(ok_f), .slot_dout(dout_f), .downloading(downloading),
    .sdram_req(req_f), .sdram_ack(sdram_ack), .sdram_addr(addr_f),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
`ifdef JTFRAME_ROMARB_STATS_EN
    , .stats_sel(stats_sel), .stats_cnt(stats_cnt_f)
`endif
  );

  jtframe_rom_arb #(.NSLOT(NSLOT), .AW(AW), .OFFSETS(OFFS), .BYTE_SLOTS(BYTES), .RR_MODE(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(ok_r), .slot_dout(dout_r), .downloading(downloading),
    .sdram_req(req_r), .sdram_ack(sdram_ack), .sdram_addr(addr_r),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
`ifdef JTFRAME_ROMARB_STATS_EN
    , .stats_sel(stats_sel), .stats_cnt(stats_cnt_r)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] d16(input logic [NSLOT*16-1:0] v, input int i);
    return v[16*i +: 16];
  endfunction

  task automatic set_slot(input int i, input logic cs, input logic [21:0] a);
    slot_cs[i] = cs;
    slot_addr[AW*i +: AW] = a;
  endtask

  task automatic dl_pulse();
    downloading = 1'b1;
    step();
    downloading = 0;
  endtask

  // One memory transaction: ack one cycle after req is seen, rdy two cycles
  // after ack. er < 0 means the round-robin copy must stay idle. chg >= 0
  // moves slot 0 to a new address while the transaction is in WAIT.
  task automatic xact(input logic [21:0] ef, input int er, input logic [15:0] d,
                      input int chg, input string tag);
    int n;
    n = 0;
    while (!req_f && n < 20) begin
      step();
      n++;
    end
    chk(req_f, 1'b1, {tag, "_req"});
    chk(addr_f, ef, {tag, "_addr_f"});
    if (er >= 0) begin
      chk(req_r, 1'b1, {tag, "_req_r"});
      chk(addr_r, er[21:0], {tag, "_addr_r"});
    end else begin
      chk(req_r, 1'b0, {tag, "_rr_idle"});
    end
    step();
    chk(req_f, 1'b1, {tag, "_req_hold"});
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk(req_f, 1'b0, {tag, "_req_drop"});
    if (chg >= 0) set_slot(0, 1'b1, chg[21:0]);
    step();
    data_rdy  = 1'b1;
    data_dst  = 1'b1;
    data_read = d;
    step();
    data_rdy  = 1'b0;
    data_dst  = 1'b0;
    data_read = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    slot_cs = '0; slot_addr = '0; downloading = 1'b0; sdram_ack = 1'b0;
    data_dst = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(ok_f, 4'h0, "rst_ok_f");
    chk(dout_f, 64'h0, "rst_dout_f");
    chk(req_f, 1'b0, "rst_req_f");
    chk(addr_f, 22'h0, "rst_addr_f");
    chk(ok_r, 4'h0, "rst_ok_r");
    chk(req_r, 1'b0, "rst_req_r");
    rst_n = 1'b1;
    step();

    // slot 0 miss through offset 0x8000
    set_slot(0, 1'b1, 22'h100);
    step();
    xact(22'h8100, 32'h8100, 16'hBEEF, -1, "t1");
    chk(ok_f[0], 1'b1, "t1_ok");
    chk(d16(dout_f, 0), 16'hBEEF, "t1_dout");

    // repeat access hits without a request
    set_slot(0, 1'b0, 22'h100);
    step();
    chk(ok_f[0], 1'b0, "t2_ok_drop");
    set_slot(0, 1'b1, 22'h100);
    step();
    chk(ok_f[0], 1'b1, "t2_ok_hit");
    chk(d16(dout_f, 0), 16'hBEEF, "t2_dout");
    chk(req_f, 1'b0, "t2_noreq");
    step();
    chk(req_f, 1'b0, "t2_noreq2");

    // byte slot: odd address takes the high byte
    set_slot(1, 1'b1, 22'h201);
    step();
    xact(22'h100, 32'h100, 16'h12AB, -1, "t3");
    chk(ok_f[1], 1'b1, "t3_ok");
    chk(d16(dout_f, 1), 16'h0012, "t3_dout_hi");
    chk(d16(dout_r, 1), 16'h0012, "t3_dout_hi_r");
    set_slot(1, 1'b1, 22'h200);
    step();
    chk(d16(dout_f, 1), 16'h00AB, "t3_dout_lo");
    chk(req_f, 1'b0, "t3_noreq");
    chk(ok_f, 4'b0011, "t3_ok_all");

    // downloading during REQ aborts and clears the caches
    set_slot(2, 1'b1, 22'h300);
    step();
    chk(req_f, 1'b1, "t4_req");
    chk(addr_f, 22'h300, "t4_addr");
    dl_pulse();
    chk(req_f, 1'b0, "t4_req_abort");
    chk(ok_f, 4'h0, "t4_ok_clr");
    chk(ok_r, 4'h0, "t4_ok_clr_r");
    chk(addr_f, 22'h0, "t4_addr_clr");
    step();
    xact(22'h8100, 32'h8100, 16'hBEEF, -1, "t4_s0");
    xact(22'h100, 32'h100, 16'h12AB, -1, "t4_s1");
    xact(22'h300, 32'h300, 16'h3333, -1, "t4_s2");
    chk(ok_f, 4'b0111, "t4_ok_all");
    chk(d16(dout_f, 2), 16'h3333, "t4_dout2");
    chk(d16(dout_f, 1), 16'h00AB, "t4_dout1");

    // address change during WAIT fills the old tag
    slot_cs = '0;
    step();
    dl_pulse();
    set_slot(0, 1'b1, 22'h100);
    step();
    xact(22'h8100, 32'h8100, 16'hBEEF, 32'h104, "t5");
    chk(ok_f[0], 1'b0, "t5_ok_low");
    set_slot(0, 1'b1, 22'h100);
    step();
    chk(ok_f[0], 1'b1, "t5_old_tag");
    chk(d16(dout_f, 0), 16'hBEEF, "t5_old_dout");
    chk(req_f, 1'b0, "t5_noreq");
    set_slot(0, 1'b1, 22'h104);
    step();
    xact(22'h8104, 32'h8104, 16'h0104, -1, "t5_new");
    chk(ok_f[0], 1'b1, "t5_new_ok");
    chk(d16(dout_f, 0), 16'h0104, "t5_new_dout");

    // simultaneous misses, then slot 0 keeps re-missing
    slot_cs = '0;
    step();
    dl_pulse();
    set_slot(0, 1'b1, 22'h400);
    set_slot(1, 1'b1, 22'h801);
    set_slot(2, 1'b1, 22'h500);
    set_slot(3, 1'b1, 22'h600);
    step();
    xact(22'h8400, 32'h8400, 16'hA000, -1, "t6a");
    xact(22'h400, 32'h400, 16'hA001, -1, "t6b");
    xact(22'h500, 32'h500, 16'hA002, -1, "t6c");
    xact(22'h600, 32'h600, 16'hA003, -1, "t6d");
    chk(ok_f, 4'hF, "t6_ok_f");
    chk(ok_r, 4'hF, "t6_ok_r");
    set_slot(0, 1'b1, 22'h404);
    set_slot(1, 1'b1, 22'h803);
    step();
    xact(22'h8404, 32'h8404, 16'hB000, 32'h408, "t6e");
    xact(22'h8408, 32'h401, 16'hB001, 32'h40C, "t6f");
    xact(22'h840C, 32'h840C, 16'hB002, -1, "t6g");
    chk(ok_r, 4'hF, "t6_rr_all_ok");
    chk(d16(dout_r, 1), 16'h00B0, "t6_rr_dout1");
    chk(ok_f, 4'b1101, "t6_fix_starve");
    xact(22'h401, -1, 16'hA1C2, -1, "t6h");
    chk(ok_f, 4'hF, "t6_fix_all_ok");
    chk(d16(dout_f, 1), 16'h00A1, "t6_fix_dout1");
    chk(d16(dout_f, 0), 16'hB002, "t6_fix_dout0");

`ifdef JTFRAME_ROMARB_STATS_EN
    stats_sel = 4'd0;
    step();
    chk(stats_cnt_f, 16'd4, "stats_f0");
    stats_sel = 4'd1;
    step();
    chk(stats_cnt_r, 16'd2, "stats_r1");
    stats_sel = 4'd9;
    step();
    chk(stats_cnt_f, 16'd0, "stats_oor");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
